vend_arbiter: RTL and testbench

VEND_ARBITER -- requirements
Module: vend_arbiter

---
 rtl/vend_arbiter.sv | 131 +++++++++++++
 tb/tb_vend_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// Two-requester vending arbiter: grants the shared dispenser, pays out change
// one coin at a time, acknowledges completion, and latches a dispenser timeout.
// Ports: CLK, nRESET; req0/req1 + chg0/chg1 in; ack0/ack1 out;
//        motor_start out, motor_done in; coin_ready in, coin_out out;
//        busy, gnt_id, fault status out.
module vend_arbiter (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] chg0,
    input  logic [2:0] chg1,
    output logic       ack0,
    output logic       ack1,
    output logic       motor_start,
    input  logic       motor_done,
    input  logic       coin_ready,
    output logic       coin_out,
    output logic       busy,
    output logic       gnt_id,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_M,
        CHANGE,
        DONE,
        FAULT
    } state_t;

    state_t     state;
    logic       ptr;
    logic       mask_en;
    logic       mask_id;
    logic [2:0] cnt;
    logic [3:0] tmo;

    logic r0;
    logic r1;
    logic pick;

    // The requester served last sits out one IDLE cycle so a req that is
    // still high while the front-end reacts to ack is not serviced twice.
    assign r0   = req0 & ~(mask_en & ~mask_id);
    assign r1   = req1 & ~(mask_en & mask_id);
    assign pick = (r0 & r1) ? ptr : r1;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            mask_en     <= 1'b0;
            mask_id     <= 1'b0;
            cnt         <= 3'd0;
            tmo         <= 4'd0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            motor_start <= 1'b0;
            coin_out    <= 1'b0;
            busy        <= 1'b0;
            gnt_id      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            motor_start <= 1'b0;
            coin_out    <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            unique case (state)
                IDLE: begin
                    mask_en <= 1'b0;
                    if (r0 | r1) begin
                        state       <= GRANT;
                        gnt_id      <= pick;
                        cnt         <= pick ? chg1 : chg0;
                        motor_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= WAIT_M;
                    tmo   <= 4'd0;
                end
                WAIT_M: begin
                    if (motor_done) begin
                        if (cnt == 3'd0) begin
                            state <= DONE;
                            ack0  <= ~gnt_id;
                            ack1  <= gnt_id;
                        end else begin
                            state <= CHANGE;
                        end
                    end else if (tmo == 4'd14) begin
                        // this was the 15th WAIT_M cycle without motor_done
                        state <= FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        tmo <= tmo + 4'd1;
                    end
                end
                CHANGE: begin
                    if (cnt == 3'd0) begin
                        state <= DONE;
                        ack0  <= ~gnt_id;
                        ack1  <= gnt_id;
                    end else if (coin_ready && !coin_out) begin
                        // coin_out low last cycle enforces 2-cycle spacing
                        coin_out <= 1'b1;
                        cnt      <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ptr     <= ~gnt_id;
                    mask_en <= 1'b1;
                    mask_id <= gnt_id;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed self-checking bench for vend_arbiter.
// One task per scenario; a monitor counts output pulses at the falling edge.
module tb_vend_arbiter;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [2:0] chg0 = 3'd0;
    logic [2:0] chg1 = 3'd0;
    logic       motor_done;
    logic       coin_ready = 1'b0;
    logic       ack0;
    logic       ack1;
    logic       motor_start;
    logic       coin_out;
    logic       busy;
    logic       gnt_id;
    logic       fault;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int ms_cnt = 0;
    int coin_cnt = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int last_coin = -100;
    int coin_gap = 0;
    int ack_seq[$];

    logic auto_en = 1'b1;
    int   auto_dly = 3;

    vend_arbiter dut (
        .CLK(CLK),
        .nRESET(nRESET),
        .req0(req0),
        .req1(req1),
        .chg0(chg0),
        .chg1(chg1),
        .ack0(ack0),
        .ack1(ack1),
        .motor_start(motor_start),
        .motor_done(motor_done),
        .coin_ready(coin_ready),
        .coin_out(coin_out),
        .busy(busy),
        .gnt_id(gnt_id),
        .fault(fault)
    );

    initial forever #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        if (motor_start) ms_cnt++;
        if (coin_out) begin
            coin_gap = cyc - last_coin;
            last_coin = cyc;
            coin_cnt++;
        end
        if (ack0) begin
            ack0_cnt++;
            ack_seq.push_back(0);
        end
        if (ack1) begin
            ack1_cnt++;
            ack_seq.push_back(1);
        end
    end

    // dispenser model: motor_done pulse auto_dly cycles after motor_start
    initial begin
        motor_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (auto_en && motor_start) begin
                repeat (auto_dly) @(posedge CLK);
                #1 motor_done = 1'b1;
                @(posedge CLK);
                #1 motor_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        tick();
        tick();
        nRESET = 1'b1;
    endtask

    task automatic wait_ack(input int who, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        nRESET = 1'b0;
        req0 = 1'b1;
        #1;
        outs = {ack0, ack1, motor_start, coin_out, busy, gnt_id, fault};
        n_cmp++;
        if (outs !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 0000000", outs);
        end
        tick();
        tick();
        outs = {ack0, ack1, motor_start, coin_out, busy, gnt_id, fault};
        n_cmp++;
        if (outs !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %b want 0000000", outs);
        end
        req0 = 1'b0;
        nRESET = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_request();
        int m0, c0, a0, a1;
        bit ok;
        m0 = ms_cnt; c0 = coin_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
        chg0 = 3'd2;
        coin_ready = 1'b1;
        auto_dly = 3;
        req0 = 1'b1;
        tick();
        n_cmp++;
        if ({busy, motor_start, gnt_id} !== 3'b110) begin
            n_bad++;
            $display("FAIL grant_outs: got %b want 110",
                     {busy, motor_start, gnt_id});
        end
        tick();
        n_cmp++;
        if (motor_start !== 1'b0) begin
            n_bad++;
            $display("FAIL start_pulse: got %b want 0", motor_start);
        end
        wait_ack(0, 100, ok);
        req0 = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_ack: got none want ack0");
        end
        tick();
        tick();
        n_cmp++;
        if (ms_cnt - m0 != 1) begin
            n_bad++;
            $display("FAIL single_starts: got %0d want 1", ms_cnt - m0);
        end
        n_cmp++;
        if (coin_cnt - c0 != 2) begin
            n_bad++;
            $display("FAIL single_coins: got %0d want 2", coin_cnt - c0);
        end
        n_cmp++;
        if (coin_gap != 2) begin
            n_bad++;
            $display("FAIL coin_gap: got %0d want 2", coin_gap);
        end
        n_cmp++;
        if (ack0_cnt - a0 != 1 || ack1_cnt - a1 != 0) begin
            n_bad++;
            $display("FAIL single_acks: got %0d/%0d want 1/0",
                     ack0_cnt - a0, ack1_cnt - a1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_contention();
        int s0, got;
        int exp_seq[3];
        exp_seq = '{0, 1, 0};
        do_reset();
        s0 = ack_seq.size();
        got = 0;
        chg0 = 3'd0;
        chg1 = 3'd0;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ack0 | ack1) begin
                got++;
                if (got == 3) break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (ack_seq.size() - s0 != 3) begin
            n_bad++;
            $display("FAIL contention_count: got %0d want 3",
                     ack_seq.size() - s0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ack_seq[s0 + i] != exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL contention_order[%0d]: got %0d want %0d",
                             i, ack_seq[s0 + i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_zero_change();
        int m0, c0, a0, a1;
        bit ok;
        m0 = ms_cnt; c0 = coin_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
        chg1 = 3'd0;
        req1 = 1'b1;
        wait_ack(1, 100, ok);
        req1 = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL zero_ack: got none want ack1");
        end
        tick();
        n_cmp++;
        if (coin_cnt - c0 != 0) begin
            n_bad++;
            $display("FAIL zero_coins: got %0d want 0", coin_cnt - c0);
        end
        n_cmp++;
        if (ms_cnt - m0 != 1) begin
            n_bad++;
            $display("FAIL zero_starts: got %0d want 1", ms_cnt - m0);
        end
        n_cmp++;
        if (ack1_cnt - a1 != 1 || ack0_cnt - a0 != 0) begin
            n_bad++;
            $display("FAIL zero_acks: got %0d/%0d want 0/1",
                     ack0_cnt - a0, ack1_cnt - a1);
        end
    endtask

    task automatic test_timeout();
        int m0, a0, a1;
        auto_en = 1'b0;
        chg0 = 3'd1;
        req0 = 1'b1;
        tick();
        n_cmp++;
        if (motor_start !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_start: got %b want 1", motor_start);
        end
        m0 = ms_cnt + 1;
        a0 = ack0_cnt; a1 = ack1_cnt;
        repeat (15) tick();
        n_cmp++;
        if ({fault, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL tmo_early: got %b want 01", {fault, busy});
        end
        tick();
        n_cmp++;
        if ({fault, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL tmo_fault: got %b want 10", {fault, busy});
        end
        req0 = 1'b0;
        req1 = 1'b1;
        auto_en = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (ms_cnt != m0 || ack0_cnt != a0 || ack1_cnt != a1) begin
            n_bad++;
            $display("FAIL fault_ignore: got starts %0d acks %0d/%0d want %0d %0d/%0d",
                     ms_cnt, ack0_cnt, ack1_cnt, m0, a0, a1);
        end
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_sticky: got %b want 1", fault);
        end
        req1 = 1'b0;
        do_reset();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_clear: got %b want 0", fault);
        end
    endtask

    task automatic test_hopper_stall();
        int c0, a0;
        bit ok;
        c0 = coin_cnt; a0 = ack0_cnt;
        chg0 = 3'd3;
        coin_ready = 1'b1;
        req0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (coin_out) begin
                ok = 1'b1;
                break;
            end
        end
        coin_ready = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL stall_first_coin: got none want coin_out");
        end
        repeat (10) tick();
        n_cmp++;
        if (coin_cnt - c0 != 1 || ack0_cnt - a0 != 0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold: got coins %0d acks %0d busy %b want 1 0 1",
                     coin_cnt - c0, ack0_cnt - a0, busy);
        end
        coin_ready = 1'b1;
        wait_ack(0, 50, ok);
        req0 = 1'b0;
        n_cmp++;
        if (!ok || coin_cnt - c0 != 3) begin
            n_bad++;
            $display("FAIL stall_ack: got ack %0d coins %0d want 1 3",
                     ok, coin_cnt - c0);
        end
        tick();
        n_cmp++;
        if (ack0_cnt - a0 != 1) begin
            n_bad++;
            $display("FAIL stall_acks: got %0d want 1", ack0_cnt - a0);
        end
    endtask

    task automatic test_reset_in_change();
        int c0, a0;
        bit ok;
        logic [6:0] outs;
        tick();
        tick();
        a0 = ack0_cnt;
        chg0 = 3'd3;
        coin_ready = 1'b1;
        req0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (coin_out) begin
                ok = 1'b1;
                break;
            end
        end
        nRESET = 1'b0;
        #1;
        outs = {ack0, ack1, motor_start, coin_out, busy, gnt_id, fault};
        n_cmp++;
        if (!ok || outs !== 7'd0) begin
            n_bad++;
            $display("FAIL midreset_outs: got coin %0d outs %b want 1 0000000",
                     ok, outs);
        end
        chg0 = 3'd1;
        tick();
        tick();
        n_cmp++;
        if (ack0_cnt != a0) begin
            n_bad++;
            $display("FAIL midreset_noack: got %0d want %0d", ack0_cnt, a0);
        end
        c0 = coin_cnt;
        a0 = ack0_cnt;
        nRESET = 1'b1;
        tick();
        n_cmp++;
        if ({busy, motor_start, gnt_id} !== 3'b110) begin
            n_bad++;
            $display("FAIL resume_grant: got %b want 110",
                     {busy, motor_start, gnt_id});
        end
        wait_ack(0, 100, ok);
        req0 = 1'b0;
        tick();
        n_cmp++;
        if (!ok || coin_cnt - c0 != 1 || ack0_cnt - a0 != 1) begin
            n_bad++;
            $display("FAIL resume_service: got ack %0d coins %0d acks %0d want 1 1 1",
                     ok, coin_cnt - c0, ack0_cnt - a0);
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_contention();
        test_zero_change();
        test_timeout();
        test_hopper_stall();
        test_reset_in_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
